laser_sig_filter: RTL and testbench

Upstream conditioning stage for the raw laser receiver input, ahead of the motor-enable logic. Provides:
- a 2-flop synchronizer;
- a consecutive-sample debounce state machine;
- single-cycle rise and fall pulses;
- saturating diagnostic counters for beam breaks and rejected glitches.

The downstream motor-enable block consumes sig_filt in place of the raw pin.

---
 rtl/laser_pkg.sv | 15 +
 rtl/sync_2ff.sv | 29 ++
 rtl/laser_sig_filter.sv | 161 ++++++++++++++++
 tb/tb_laser_sig_filter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared definitions for the laser receiver conditioning path.
//   state_t          : debounce FSM state encoding (2 bits)
//   DEBOUNCE_DEFAULT : default number of consecutive cycles a new level must hold
package laser_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 1000;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

endpackage : laser_pkg

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous sensor inputs.
//   clk  : destination clock
//   rstn : asynchronous active-low reset, both flops clear to 0
//   d    : asynchronous input
//   q    : synchronized output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic s1;
  logic s0;

  // Metastability chain: d -> s1 -> s0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s0 <= 1'b0;
    end else begin
      s1 <= d;
      s0 <= s1;
    end
  end

  assign q = s0;

endmodule : sync_2ff

// File: rtl/laser_sig_filter.sv
// Laser receiver conditioning: synchronizes the raw pin, debounces it with a
// consecutive-sample FSM, emits single-cycle edge pulses and keeps saturating
// counts of confirmed beam breaks and rejected glitches.
//   clk        : system clock
//   rstn       : asynchronous active-low reset
//   laser_sig  : raw asynchronous receiver output (1 = beam received)
//   cnt_clr    : synchronous clear of break_cnt and glitch_cnt
//   sig_filt   : debounced, synchronized laser level
//   rise_pulse : one-cycle pulse after sig_filt goes 0->1
//   fall_pulse : one-cycle pulse after sig_filt goes 1->0
//   break_cnt  : saturating count of confirmed falls
//   glitch_cnt : saturating count of aborted level changes
module laser_sig_filter
  import laser_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned EVT_W           = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             laser_sig,
  input  logic             cnt_clr,
  output logic             sig_filt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [EVT_W-1:0] break_cnt,
  output logic [EVT_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [EVT_W-1:0] EVT_MAX   = {EVT_W{1'b1}};

  logic             s0;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] deb_cnt_nxt;
  logic             sig_filt_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  logic             break_inc;
  logic             glitch_inc;
  logic [EVT_W-1:0] break_nxt;
  logic [EVT_W-1:0] glitch_nxt;

  sync_2ff u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (laser_sig),
    .q    (s0)
  );

  // State register plus all registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= LOW;
      deb_cnt    <= '0;
      sig_filt   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      break_cnt  <= '0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_nxt;
      deb_cnt    <= deb_cnt_nxt;
      sig_filt   <= sig_filt_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      break_cnt  <= break_nxt;
      glitch_cnt <= glitch_nxt;
    end
  end

  // Next-state: count consecutive cycles of the candidate level
  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    unique case (state)
      LOW: begin
        if (s0) begin
          state_nxt   = RISE_CHK;
          deb_cnt_nxt = CNT_W'(1);
        end
      end
      RISE_CHK: begin
        if (!s0) begin
          state_nxt   = LOW;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LIMIT) begin
          state_nxt   = HIGH;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s0) begin
          state_nxt   = FALL_CHK;
          deb_cnt_nxt = CNT_W'(1);
        end
      end
      FALL_CHK: begin
        if (s0) begin
          state_nxt   = HIGH;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LIMIT) begin
          state_nxt   = LOW;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt   = LOW;
        deb_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs: level/pulse updates on confirmation, counter events on abort/fall
  always_comb begin
    sig_filt_nxt = sig_filt;
    rise_nxt     = 1'b0;
    fall_nxt     = 1'b0;
    break_inc    = 1'b0;
    glitch_inc   = 1'b0;
    unique case (state)
      RISE_CHK: begin
        if (!s0) begin
          glitch_inc = 1'b1;
        end else if (deb_cnt == DEB_LIMIT) begin
          sig_filt_nxt = 1'b1;
          rise_nxt     = 1'b1;
        end
      end
      FALL_CHK: begin
        if (s0) begin
          glitch_inc = 1'b1;
        end else if (deb_cnt == DEB_LIMIT) begin
          sig_filt_nxt = 1'b0;
          fall_nxt     = 1'b1;
          break_inc    = 1'b1;
        end
      end
      default: ;
    endcase

    // Clear wins over a same-cycle increment; increments stop at all-ones
    if (cnt_clr) begin
      break_nxt  = '0;
      glitch_nxt = '0;
    end else begin
      break_nxt  = (break_inc && (break_cnt != EVT_MAX))
                   ? break_cnt + EVT_W'(1) : break_cnt;
      glitch_nxt = (glitch_inc && (glitch_cnt != EVT_MAX))
                   ? glitch_cnt + EVT_W'(1) : glitch_cnt;
    end
  end

endmodule : laser_sig_filter

// File: tb/tb_laser_sig_filter.sv
// Directed bench for laser_sig_filter with DEBOUNCE_CYCLES=4, EVT_W=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// half a cycle after the rising edge that updates them. With inputs set at a
// negedge, the next posedge is the capture edge k, and sig_filt is expected to
// change at edge k+6 (k+2+DEBOUNCE_CYCLES).
module tb_laser_sig_filter;

  localparam int unsigned DEB   = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned EVT_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             laser_sig;
  logic             cnt_clr;
  logic             sig_filt;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [EVT_W-1:0] break_cnt;
  logic [EVT_W-1:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  laser_sig_filter #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W),
    .EVT_W           (EVT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .laser_sig  (laser_sig),
    .cnt_clr    (cnt_clr),
    .sig_filt   (sig_filt),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .break_cnt  (break_cnt),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sig_filt"},   32'(sig_filt),   32'd0);
    check({tag, "_rise"},       32'(rise_pulse), 32'd0);
    check({tag, "_fall"},       32'(fall_pulse), 32'd0);
    check({tag, "_break_cnt"},  32'(break_cnt),  32'd0);
    check({tag, "_glitch_cnt"}, 32'(glitch_cnt), 32'd0);
  endtask

  initial begin
    int exp_brk;
    int exp_glt;

    rstn      = 1'b0;
    laser_sig = 1'b1;
    cnt_clr   = 1'b0;
    cycles(3);
    check_all_zero("reset");

    // Reset release with laser held high: edge 1 captures, sig_filt rises at edge 7
    rstn = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      check($sformatf("pwrup_sig_e%0d", e),  32'(sig_filt),   32'(e >= 7));
      check($sformatf("pwrup_rise_e%0d", e), 32'(rise_pulse), 32'(e == 7));
    end
    check("pwrup_glitch", 32'(glitch_cnt), 32'd0);

    // Two-cycle low glitch while HIGH: rejected, counted once, no pulses
    laser_sig = 1'b0;
    cycles(2);
    laser_sig = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      check($sformatf("glitch_sig_e%0d", e),  32'(sig_filt),   32'd1);
      check($sformatf("glitch_fall_e%0d", e), 32'(fall_pulse), 32'd0);
      check($sformatf("glitch_rise_e%0d", e), 32'(rise_pulse), 32'd0);
    end
    check("glitch_cnt_1", 32'(glitch_cnt), 32'd1);
    check("glitch_break", 32'(break_cnt),  32'd0);

    // Held low: sig_filt falls at capture edge + 6 with one fall pulse
    laser_sig = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      check($sformatf("fall_sig_e%0d", e),   32'(sig_filt),   32'(e < 7));
      check($sformatf("fall_pulse_e%0d", e), 32'(fall_pulse), 32'(e == 7));
    end
    check("fall_break_1", 32'(break_cnt), 32'd1);
    cycles(1);

    // Twenty more confirmed breaks: count must stop at 15
    exp_brk = 1;
    for (int i = 0; i < 20; i++) begin
      laser_sig = 1'b1;
      cycles(10);
      laser_sig = 1'b0;
      cycles(10);
      exp_brk = (exp_brk < 15) ? exp_brk + 1 : 15;
      check($sformatf("sat_break_%0d", i), 32'(break_cnt), 32'(exp_brk));
    end

    // Clear coincident with the confirming fall edge (edge 7): clear wins
    laser_sig = 1'b1;
    cycles(10);
    laser_sig = 1'b0;
    cycles(6);
    check("clrfall_pre_sig", 32'(sig_filt), 32'd1);
    cnt_clr = 1'b1;
    cycles(1);
    cnt_clr = 1'b0;
    check("clrfall_pulse",  32'(fall_pulse), 32'd1);
    check("clrfall_sig",    32'(sig_filt),   32'd0);
    check("clrfall_break",  32'(break_cnt),  32'd0);
    check("clrfall_glitch", 32'(glitch_cnt), 32'd0);
    cycles(1);
    check("clrfall_break_hold", 32'(break_cnt), 32'd0);

    // One confirmed break so that both counters are nonzero before the clear
    laser_sig = 1'b1;
    cycles(10);
    laser_sig = 1'b0;
    cycles(10);
    check("pre_glitch_break", 32'(break_cnt), 32'd1);

    // Eighteen two-cycle high glitches from LOW: count stops at 15
    exp_glt = 0;
    for (int i = 0; i < 18; i++) begin
      laser_sig = 1'b1;
      cycles(2);
      laser_sig = 1'b0;
      cycles(8);
      exp_glt = (exp_glt < 15) ? exp_glt + 1 : 15;
      check($sformatf("sat_glitch_%0d", i), 32'(glitch_cnt), 32'(exp_glt));
    end
    check("sat_glitch_sig",   32'(sig_filt),  32'd0);
    check("sat_glitch_break", 32'(break_cnt), 32'd1);

    cnt_clr = 1'b1;
    cycles(1);
    cnt_clr = 1'b0;
    check("clr_break",  32'(break_cnt),  32'd0);
    check("clr_glitch", 32'(glitch_cnt), 32'd0);

    // Reset mid rise check: s0 high seen at edges k+2..k+4 gives deb_cnt=3
    laser_sig = 1'b1;
    cycles(5);
    check("midchk_sig", 32'(sig_filt), 32'd0);
    rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    cycles(2);
    rstn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      check($sformatf("restart_sig_e%0d", e),  32'(sig_filt),   32'(e >= 7));
      check($sformatf("restart_rise_e%0d", e), 32'(rise_pulse), 32'(e == 7));
    end
    check("restart_glitch", 32'(glitch_cnt), 32'd0);
    check("restart_break",  32'(break_cnt),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_laser_sig_filter
